// File: rtl/deflate_cl_pkg.sv
// Shared constants and types for the DEFLATE code-length (CL) alphabet recoder.
package deflate_cl_pkg;

  localparam int NUM_CL_SYMS = 19;

  localparam logic [4:0] CL_REP_PREV = 5'd16;
  localparam logic [4:0] CL_REP_Z3   = 5'd17;
  localparam logic [4:0] CL_REP_Z11  = 5'd18;

  localparam int CL_REP_MIN  = 3;
  localparam int CL_PREV_MAX = 6;
  localparam int CL_Z3_MAX   = 10;
  localparam int CL_Z11_MIN  = 11;
  localparam int CL_Z11_MAX  = 138;

  localparam logic [2:0] CL_XW_PREV = 3'd2;
  localparam logic [2:0] CL_XW_Z3   = 3'd3;
  localparam logic [2:0] CL_XW_Z11  = 3'd7;

  // Order in which the CL code lengths themselves are transmitted in the block header.
  localparam logic [4:0] CL_PERM [NUM_CL_SYMS] = '{
    5'd16, 5'd17, 5'd18, 5'd0, 5'd8, 5'd7, 5'd9, 5'd6, 5'd10, 5'd5,
    5'd11, 5'd4, 5'd12, 5'd3, 5'd13, 5'd2, 5'd14, 5'd1, 5'd15
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_DONE
  } cl_state_e;

endpackage

// File: rtl/cl_rle_pick.sv
// Chooses the next CL symbol for the head of a run: literal, 16 (repeat previous),
// 17 (short zero run) or 18 (long zero run), and how many lengths it covers.
module cl_rle_pick
  import deflate_cl_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int RUN_W  = 8,
  parameter bit RLE_EN = 1'b1
) (
  input  logic [LEN_W-1:0] val,
  input  logic [RUN_W-1:0] rem,
  input  logic             lit_sent,
  output logic [4:0]       sym,
  output logic [6:0]       extra,
  output logic [2:0]       extra_len,
  output logic [RUN_W-1:0] consume
);

  logic [RUN_W-1:0] zcap;
  logic [RUN_W-1:0] pcap;

  assign zcap = (int'(rem) > CL_Z11_MAX)  ? RUN_W'(CL_Z11_MAX)  : rem;
  assign pcap = (int'(rem) > CL_PREV_MAX) ? RUN_W'(CL_PREV_MAX) : rem;

  always_comb begin
    sym       = 5'(val);
    extra     = '0;
    extra_len = '0;
    consume   = RUN_W'(1);
    if (RLE_EN) begin
      if (val == '0) begin
        if (int'(rem) >= CL_Z11_MIN) begin
          sym       = CL_REP_Z11;
          extra     = 7'(int'(zcap) - CL_Z11_MIN);
          extra_len = CL_XW_Z11;
          consume   = zcap;
        end else if (int'(rem) >= CL_REP_MIN && int'(rem) <= CL_Z3_MAX) begin
          sym       = CL_REP_Z3;
          extra     = 7'(int'(rem) - CL_REP_MIN);
          extra_len = CL_XW_Z3;
          consume   = rem;
        end
      end else if (lit_sent && int'(rem) >= CL_REP_MIN) begin
        // A nonzero run must put one literal on the wire before 16 can refer back to it.
        sym       = CL_REP_PREV;
        extra     = 7'(int'(pcap) - CL_REP_MIN);
        extra_len = CL_XW_PREV;
        consume   = pcap;
      end
    end
  end

endmodule

// File: rtl/cl_rle_recoder.sv
// Run-length recodes a block of literal/length + distance code lengths into the
// 19-symbol CL alphabet and builds the per-block CL symbol histogram.
module cl_rle_recoder
  import deflate_cl_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int MAX_SYMS = 320,
  parameter int CNT_W    = 9,
  parameter bit RLE_EN   = 1'b1,
  parameter int MAX_RUN  = 138
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_sym,
  output logic [6:0]       out_extra,
  output logic [2:0]       out_extra_len,
  output logic             out_last,
  output logic             done,
  input  logic [4:0]       hist_rd_idx,
  output logic [CNT_W-1:0] hist_rd_data,
  output logic             err_overflow
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int BLK_W = $clog2(MAX_SYMS + 2);

  cl_state_e        state_q, state_d;
  logic [LEN_W-1:0] run_val_q, run_val_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             lit_sent_q, lit_sent_d;
  logic             have_run_q, have_run_d;
  logic             final_q, final_d;
  logic             pend_vld_q, pend_vld_d;
  logic [LEN_W-1:0] pend_val_q, pend_val_d;
  logic             pend_last_q, pend_last_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             err_q, err_d;
  logic [NUM_CL_SYMS-1:0][CNT_W-1:0] hist_q, hist_d;

  logic [4:0]       pk_sym;
  logic [6:0]       pk_extra;
  logic [2:0]       pk_extra_len;
  logic [RUN_W-1:0] pk_consume;
  logic [RUN_W-1:0] rem_nxt;

  cl_rle_pick #(
    .LEN_W (LEN_W),
    .RUN_W (RUN_W),
    .RLE_EN(RLE_EN)
  ) u_pick (
    .val      (run_val_q),
    .rem      (run_cnt_q),
    .lit_sent (lit_sent_q),
    .sym      (pk_sym),
    .extra    (pk_extra),
    .extra_len(pk_extra_len),
    .consume  (pk_consume)
  );

  always_comb begin
    state_d     = state_q;
    run_val_d   = run_val_q;
    run_cnt_d   = run_cnt_q;
    lit_sent_d  = lit_sent_q;
    have_run_d  = have_run_q;
    final_d     = final_q;
    pend_vld_d  = pend_vld_q;
    pend_val_d  = pend_val_q;
    pend_last_d = pend_last_q;
    blk_cnt_d   = blk_cnt_q;
    err_d       = err_q;
    hist_d      = hist_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    rem_nxt     = run_cnt_q - pk_consume;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d    = ST_ACCUM;
          hist_d     = '0;
          err_d      = 1'b0;
          blk_cnt_d  = '0;
          have_run_d = 1'b0;
          final_d    = 1'b0;
          pend_vld_d = 1'b0;
          lit_sent_d = 1'b0;
        end
      end

      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (int'(blk_cnt_q) <= MAX_SYMS) blk_cnt_d = blk_cnt_q + BLK_W'(1);
          if (int'(blk_cnt_q) >= MAX_SYMS) err_d = 1'b1;
          if (!have_run_q || (in_len == run_val_q && int'(run_cnt_q) < MAX_RUN)) begin
            run_val_d  = in_len;
            run_cnt_d  = have_run_q ? run_cnt_q + RUN_W'(1) : RUN_W'(1);
            have_run_d = 1'b1;
            lit_sent_d = 1'b0;
            if (in_last) begin
              state_d = ST_FLUSH;
              final_d = 1'b1;
            end
          end else begin
            // Breaking length is parked; it seeds the next run once this one drains.
            pend_vld_d  = 1'b1;
            pend_val_d  = in_len;
            pend_last_d = in_last;
            state_d     = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (hist_q[pk_sym] != '1) hist_d[pk_sym] = hist_q[pk_sym] + CNT_W'(1);
          run_cnt_d  = rem_nxt;
          lit_sent_d = 1'b1;
          if (rem_nxt == '0) begin
            if (pend_vld_q) begin
              run_val_d  = pend_val_q;
              run_cnt_d  = RUN_W'(1);
              lit_sent_d = 1'b0;
              pend_vld_d = 1'b0;
              if (pend_last_q) final_d = 1'b1;
              else             state_d = ST_ACCUM;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      run_val_q   <= '0;
      run_cnt_q   <= '0;
      lit_sent_q  <= 1'b0;
      have_run_q  <= 1'b0;
      final_q     <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_val_q  <= '0;
      pend_last_q <= 1'b0;
      blk_cnt_q   <= '0;
      err_q       <= 1'b0;
      hist_q      <= '0;
    end else begin
      state_q     <= state_d;
      run_val_q   <= run_val_d;
      run_cnt_q   <= run_cnt_d;
      lit_sent_q  <= lit_sent_d;
      have_run_q  <= have_run_d;
      final_q     <= final_d;
      pend_vld_q  <= pend_vld_d;
      pend_val_q  <= pend_val_d;
      pend_last_q <= pend_last_d;
      blk_cnt_q   <= blk_cnt_d;
      err_q       <= err_d;
      hist_q      <= hist_d;
    end
  end

  assign out_sym       = out_valid ? pk_sym       : '0;
  assign out_extra     = out_valid ? pk_extra     : '0;
  assign out_extra_len = out_valid ? pk_extra_len : '0;
  // Last symbol of the final run: no parked length and this symbol drains the count.
  assign out_last      = out_valid & final_q & ~pend_vld_q & (pk_consume == run_cnt_q);
  assign err_overflow  = err_q;
  assign hist_rd_data  = (int'(hist_rd_idx) < NUM_CL_SYMS) ? hist_q[hist_rd_idx] : '0;

endmodule

// File: tb/tb_cl_rle_recoder.sv
// Randomized bench for cl_rle_recoder against a run-splitting reference model.
module tb_cl_rle_recoder;

  localparam int MAX_SYMS = 320;
  localparam int CNT_W    = 9;
  localparam int MAX_RUN  = 138;

  typedef struct {
    int sym;
    int x;
    int xl;
    bit last;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0]       in_len = '0;
  logic [4:0]       hist_rd_idx = '0;
  logic             in_ready, out_valid, out_last, done, err_overflow;
  logic [4:0]       out_sym;
  logic [6:0]       out_extra;
  logic [2:0]       out_extra_len;
  logic [CNT_W-1:0] hist_rd_data;

  logic             l_start = 1'b0, l_in_valid = 1'b0, l_in_last = 1'b0, l_out_ready = 1'b1;
  logic [3:0]       l_in_len = '0;
  logic [4:0]       l_hist_rd_idx = '0;
  logic             l_in_ready, l_out_valid, l_out_last, l_done, l_err_overflow;
  logic [4:0]       l_out_sym;
  logic [6:0]       l_out_extra;
  logic [2:0]       l_out_extra_len;
  logic [CNT_W-1:0] l_hist_rd_data;

  cl_rle_recoder #(.MAX_SYMS(MAX_SYMS), .CNT_W(CNT_W), .RLE_EN(1'b1), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_len(in_len), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_extra(out_extra), .out_extra_len(out_extra_len),
    .out_last(out_last), .done(done), .hist_rd_idx(hist_rd_idx),
    .hist_rd_data(hist_rd_data), .err_overflow(err_overflow)
  );

  cl_rle_recoder #(.MAX_SYMS(MAX_SYMS), .CNT_W(CNT_W), .RLE_EN(1'b0), .MAX_RUN(MAX_RUN)) dut_lit (
    .clk(clk), .reset(rst_n), .start(l_start), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_len(l_in_len), .in_last(l_in_last), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_sym(l_out_sym), .out_extra(l_out_extra), .out_extra_len(l_out_extra_len),
    .out_last(l_out_last), .done(l_done), .hist_rd_idx(l_hist_rd_idx),
    .hist_rd_data(l_hist_rd_data), .err_overflow(l_err_overflow)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   lens_q[$];
  sym_t exp_q[$];
  int   hist_run[19];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input sym_t s);
    return {5'(s.sym), 7'(s.x), 3'(s.xl), s.last};
  endfunction

  // Split the block into maximal equal-value runs (capped at MAX_RUN), then cover
  // each run greedily with CL symbols.
  task automatic build_exp(input bit rle);
    int i, n, v, c, rem, k, s, x, xl;
    bit first, last_run;
    exp_q.delete();
    n = lens_q.size();
    i = 0;
    while (i < n) begin
      v = lens_q[i];
      c = 1;
      while (i + c < n && lens_q[i + c] == v && c < MAX_RUN) c++;
      last_run = (i + c == n);
      rem = c;
      first = 1'b1;
      while (rem > 0) begin
        if (!rle)                              begin s = v;  x = 0;     xl = 0; k = 1; end
        else if (v == 0 && rem >= 11)          begin k = (rem > 138) ? 138 : rem; s = 18; x = k - 11; xl = 7; end
        else if (v == 0 && rem >= 3)           begin k = rem; s = 17; x = rem - 3; xl = 3; end
        else if (v != 0 && !first && rem >= 3) begin k = (rem > 6) ? 6 : rem; s = 16; x = k - 3; xl = 2; end
        else                                   begin s = v;  x = 0;     xl = 0; k = 1; end
        rem -= k;
        first = 1'b0;
        exp_q.push_back('{s, x, xl, last_run && rem == 0});
      end
      i += c;
    end
  endtask

  task automatic gen_rand(input int target);
    int v, r;
    lens_q.delete();
    while (lens_q.size() < target) begin
      v = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
      r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 160)) : int'($urandom_range(1, 12));
      for (int k = 0; k < r && lens_q.size() < target; k++) lens_q.push_back(v);
    end
  endtask

  // mode 0: full throughput; 1: random valid/ready; 2: hold ready low 5 cycles at a 16.
  task automatic run_block(input int mode, input bit abort);
    int idx, got, cyc, stall, n, hi;
    bit held;
    logic [15:0] held_v, cur;
    int exp_h[19];
    n = lens_q.size();
    idx = 0; got = 0; cyc = 0; stall = 0; held = 1'b0; held_v = '0;
    foreach (hist_run[i]) hist_run[i] = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_err_clr", err_overflow, 0);
    chk("start_done_clr", done, 0);
    while (!done && cyc < 20000) begin
      in_valid = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_len   = (idx < n) ? 4'(lens_q[idx]) : 4'd0;
      in_last  = (idx == n - 1);
      if (mode == 1) out_ready = ($urandom_range(0, 1) != 0);
      else if (mode == 2) begin
        out_ready = !(out_valid && out_sym == 5'd16 && stall < 5);
        if (!out_ready) stall++;
      end else out_ready = 1'b1;
      hist_rd_idx = (mode == 2) ? 5'd16 : 5'($urandom_range(0, 20));
      #1;
      hi = int'(hist_rd_idx);
      chk("hist_live", 32'(hist_rd_data), (hi < 19) ? hist_run[hi] : 0);
      cur = {out_sym, out_extra, out_extra_len, out_last};
      if (held) chk("stall_hold", {out_valid, cur}, {1'b1, held_v});
      if (out_valid) chk("in_rdy_flush", in_ready, 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) chk("sym", cur, pk(exp_q[got]));
        else chk("sym_count", got + 1, exp_q.size());
        hist_run[out_sym]++;
        got++;
      end
      held = out_valid && !out_ready;
      held_v = cur;
      if (abort && out_valid) break;
      @(negedge clk);
      cyc++;
    end
    if (!abort) begin
      in_valid = 1'b0;
      chk("done", done, 1);
      chk("nsyms", got, exp_q.size());
      if (mode == 2) chk("stall_seen", stall, 5);
      foreach (exp_h[i]) exp_h[i] = 0;
      foreach (exp_q[i]) exp_h[exp_q[i].sym]++;
      for (int i = 0; i < 21; i++) begin
        hist_rd_idx = 5'(i);
        #1;
        chk("hist_final", 32'(hist_rd_data), (i < 19) ? exp_h[i] : 0);
      end
      chk("overflow", err_overflow, n > MAX_SYMS);
    end
  endtask

  task automatic load_t1();
    lens_q.delete();
    repeat (8) lens_q.push_back(8);
  endtask

  task automatic load_t2();
    lens_q.delete();
    repeat (150) lens_q.push_back(0);
    lens_q.push_back(5);
  endtask

  initial begin
    int idx, got, cyc;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_out_fields", {out_sym, out_extra, out_extra_len}, 0);
    for (int i = 0; i < 19; i++) begin
      hist_rd_idx = 5'(i);
      #1;
      chk("rst_hist", hist_rd_data, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    load_t1(); build_exp(1'b1); run_block(0, 1'b0);
    load_t2(); build_exp(1'b1); run_block(0, 1'b0);
    lens_q = {0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    build_exp(1'b1); run_block(1, 1'b0);
    load_t1(); build_exp(1'b1); run_block(2, 1'b0);

    // Reset while the long zero run is being flushed.
    load_t2(); build_exp(1'b1); run_block(0, 1'b1);
    chk("flush_seen", out_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 19; i++) begin
      hist_rd_idx = 5'(i);
      #1;
      chk("mid_rst_hist", hist_rd_data, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    load_t1(); build_exp(1'b1); run_block(1, 1'b0);

    repeat (8) begin
      gen_rand(int'($urandom_range(1, 200)));
      build_exp(1'b1);
      run_block(1, 1'b0);
    end

    gen_rand(MAX_SYMS + 1); build_exp(1'b1); run_block(1, 1'b0);
    gen_rand(MAX_SYMS);     build_exp(1'b1); run_block(0, 1'b0);

    // Literal-only build: four zeros.
    lens_q = {0, 0, 0, 0};
    build_exp(1'b0);
    @(negedge clk); l_start = 1'b1;
    @(negedge clk); l_start = 1'b0;
    idx = 0; got = 0; cyc = 0;
    while (!l_done && cyc < 200) begin
      l_in_valid = (idx < 4);
      l_in_len   = 4'd0;
      l_in_last  = (idx == 3);
      #1;
      if (l_in_valid && l_in_ready) idx++;
      if (l_out_valid) begin
        if (got < exp_q.size())
          chk("lit_sym", {l_out_sym, l_out_extra, l_out_extra_len, l_out_last}, pk(exp_q[got]));
        else chk("lit_count", got + 1, exp_q.size());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    l_in_valid = 1'b0;
    chk("lit_done", l_done, 1);
    chk("lit_nsyms", got, 4);
    l_hist_rd_idx = 5'd0;
    #1;
    chk("lit_hist0", l_hist_rd_data, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
